// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader.
// Loader state encoding, logical-unit op codes, debounce counter sizing.
package operand_loader_pkg;

    // Loader states; the encoding is also driven onto the LED state port.
    typedef enum logic [1:0] {
        LOAD_X  = 2'b00,
        LOAD_Y  = 2'b01,
        LOAD_OP = 2'b10,
        READY   = 2'b11
    } load_state_e;

    // Op codes understood by the downstream logical unit.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Operand bundle handed to the logical unit.
    typedef struct packed {
        logic [7:0] sendi;
        logic [1:0] sel;
    } operand_t;

    // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/operand_loader_key.sv
// Pushbutton conditioning: 2-flop synchronizer, debounce counter, press pulse.
// Ports: clk, reset (sync, active-high), key_n (raw, active-low), press (1-cycle).
module key_debounce
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_s1_q;
    logic             key_s2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_q;
    logic             press_d;
    logic             key_pressed_s;

    // level_q: 1 = accepted pressed, 0 = accepted released.
    assign key_pressed_s = ~key_s2_q;
    assign cnt_inc       = cnt_q + 1'b1;

    // The flip is taken on the edge where the count reaches CNT_MAX, so
    // press is registered in the same edge and the counter never rests at
    // CNT_MAX; this keeps the capture at edge 2+DEBOUNCE_CYCLES.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (key_pressed_s != level_q) begin
            if (cnt_inc == CNT_MAX) begin
                level_d = key_pressed_s;
                press_d = key_pressed_s;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            level_q  <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Four-state operand loader for the 8-bit logical unit.
// Ports: clk, reset, key_n, sw[3:0], op_sw[1:0] in; sendi, sel, valid, state out.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] sw,
    input  logic [1:0] op_sw,
    output logic [7:0] sendi,
    output logic [1:0] sel,
    output logic       valid,
    output logic [1:0] state
);

    logic        press;
    logic [3:0]  sw_s1_q;
    logic [3:0]  sw_s2_q;
    logic [1:0]  op_s1_q;
    logic [1:0]  op_s2_q;

    load_state_e state_q;
    load_state_e state_d;
    operand_t    opnd_q;
    operand_t    opnd_d;
    logic        valid_q;
    logic        valid_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk  (clk),
        .reset(reset),
        .key_n(key_n),
        .press(press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            op_s1_q <= '0;
            op_s2_q <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            op_s1_q <= op_sw;
            op_s2_q <= op_s1_q;
        end
    end

    // Switches are only looked at on a press edge; otherwise all holds.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        valid_d = valid_q;
        if (press) begin
            unique case (state_q)
                LOAD_X: begin
                    opnd_d.sendi[7:4] = sw_s2_q;
                    state_d           = LOAD_Y;
                end
                LOAD_Y: begin
                    opnd_d.sendi[3:0] = sw_s2_q;
                    state_d           = LOAD_OP;
                end
                LOAD_OP: begin
                    opnd_d.sel = op_s2_q;
                    state_d    = READY;
                    valid_d    = 1'b1;
                end
                READY: begin
                    state_d = LOAD_X;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = LOAD_X;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_X;
            opnd_q  <= '{sendi: 8'h00, sel: OP_AND};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            valid_q <= valid_d;
        end
    end

    assign sendi = opnd_q.sendi;
    assign sel   = opnd_q.sel;
    assign valid = valid_q;
    assign state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with a short debounce window.
// Vector table plus scoreboard of expected outputs at each state change.
module tb_operand_loader;

    logic       clk;
    logic       reset;
    logic       key_n;
    logic [3:0] sw;
    logic [1:0] op_sw;
    logic [7:0] sendi;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    operand_loader #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .key_n(key_n),
        .sw   (sw),
        .op_sw(op_sw),
        .sendi(sendi),
        .sel  (sel),
        .valid(valid),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        logic [1:0] op;
        int         low;
        bit         chg;
        logic [7:0] sendi;
        logic [1:0] sel;
        logic       valid;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[11];

    // {sendi, sel, valid, state} expected at the next state change
    logic [12:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every state change pops one expectation;
    // operands must not move while valid stays high.
    logic [1:0] m_state;
    logic [7:0] m_sendi;
    logic [1:0] m_sel;
    logic       m_valid;

    always @(posedge clk) begin
        logic [12:0] e;
        #1;
        if (!reset) begin
            if (m_valid && valid) begin
                total++;
                if (sendi !== m_sendi || sel !== m_sel) begin
                    bad++;
                    $display("FAIL stable: got %0h/%0h expected %0h/%0h",
                             sendi, sel, m_sendi, m_sel);
                end
            end
            if (state !== m_state) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got state %0d expected %0d",
                             state, m_state);
                end else begin
                    e = exp_q.pop_front();
                    if ({sendi, sel, valid, state} !== e) begin
                        bad++;
                        $display("FAIL scoreboard: got %0h expected %0h",
                                 {sendi, sel, valid, state}, e);
                    end
                end
            end
        end
        m_state = state;
        m_sendi = sendi;
        m_sel   = sel;
        m_valid = valid;
    end

    initial begin
        logic [1:0] prev;
        int         first;

        tbl[0]  = '{4'h0, 2'd0, 3,  1'b0, 8'h00, 2'd0, 1'b0, 2'd0};
        tbl[1]  = '{4'h0, 2'd0, 3,  1'b0, 8'h00, 2'd0, 1'b0, 2'd0};
        tbl[2]  = '{4'h0, 2'd0, 3,  1'b0, 8'h00, 2'd0, 1'b0, 2'd0};
        tbl[3]  = '{4'h0, 2'd0, 3,  1'b0, 8'h00, 2'd0, 1'b0, 2'd0};
        tbl[4]  = '{4'h0, 2'd0, 3,  1'b0, 8'h00, 2'd0, 1'b0, 2'd0};
        tbl[5]  = '{4'hA, 2'd0, 10, 1'b1, 8'hA0, 2'd0, 1'b0, 2'd1};
        tbl[6]  = '{4'h5, 2'd0, 10, 1'b1, 8'hA5, 2'd0, 1'b0, 2'd2};
        tbl[7]  = '{4'h5, 2'd2, 10, 1'b1, 8'hA5, 2'd2, 1'b1, 2'd3};
        tbl[8]  = '{4'h3, 2'd1, 10, 1'b1, 8'hA5, 2'd2, 1'b0, 2'd0};
        tbl[9]  = '{4'hF, 2'd1, 50, 1'b1, 8'hF5, 2'd2, 1'b0, 2'd1};
        tbl[10] = '{4'hC, 2'd1, 10, 1'b1, 8'hFC, 2'd2, 1'b0, 2'd2};

        reset = 1'b1;
        key_n = 1'b1;
        sw    = 4'h0;
        op_sw = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sendi", 32'(sendi), 32'h00);
        check("rst_sel",   32'(sel),   32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_state", 32'(state), 32'h0);

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            sw    = tbl[v].sw;
            op_sw = tbl[v].op;
            repeat (3) @(negedge clk);
            if (tbl[v].chg)
                exp_q.push_back({tbl[v].sendi, tbl[v].sel,
                                 tbl[v].valid, tbl[v].st});
            prev  = state;
            first = -1;
            key_n = 1'b0;
            for (int i = 0; i < tbl[v].low; i++) begin
                @(posedge clk);
                #1;
                if (first < 0 && state !== prev)
                    first = i;
            end
            @(negedge clk);
            key_n = 1'b1;
            repeat (12) @(negedge clk);
            check($sformatf("edge_%0d", v), 32'(first),
                  tbl[v].chg ? 32'd6 : 32'hFFFF_FFFF);
            check($sformatf("sendi_%0d", v), 32'(sendi), 32'(tbl[v].sendi));
            check($sformatf("sel_%0d", v),   32'(sel),   32'(tbl[v].sel));
            check($sformatf("valid_%0d", v), 32'(valid), 32'(tbl[v].valid));
            check($sformatf("state_%0d", v), 32'(state), 32'(tbl[v].st));
        end

        // Reset in LOAD_OP with the key already going low and still held.
        @(negedge clk);
        sw    = 4'h7;
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_sendi", 32'(sendi), 32'h00);
        check("mid_rst_sel",   32'(sel),   32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_state", 32'(state), 32'h0);
        exp_q.push_back({8'h70, 2'd0, 1'b0, 2'd1});
        @(negedge clk);
        reset = 1'b0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (first < 0 && state !== 2'd0)
                first = i;
        end
        @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_edge",  32'(first), 32'd6);
        check("post_rst_sendi", 32'(sendi), 32'h70);
        check("post_rst_state", 32'(state), 32'h1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
